modn_updown_counter: RTL and testbench

//  - Parametrised modulo-N synchronous up/down counter with parallel load, enable and cascade output.
//  - Successor to the single-bit flop / ripple counter chain.
//  - Generalises width and modulus; adds direction, load, terminal-count and overflow tracking.
//  - Used standalone or cascaded (tc of stage k drives en of stage k+1) for multi-digit counters.

---
 rtl/counter_pkg.sv | 9 +
 rtl/dff_vec.sv | 19 +
 rtl/modn_updown_counter.sv | 94 +++++++++
 tb/tb_modn_updown_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N counter family: mode encodings.
package counter_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage : counter_pkg

// File: rtl/dff_vec.sv
// Width-parameterised D register with asynchronous active-high reset.
module dff_vec #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on every rising edge; reset forces RESET_VAL at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, so register order never matters.
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

endmodule : dff_vec

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with saturating parallel load, count enable,
// cascade terminal-count output, one-cycle wrap pulse and sticky overflow.
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  // Comparisons run one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX_C};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero, load_big;
  logic             step_up, step_down;

  assign at_max    = ({1'b0, count_q} == MAX_X);
  assign at_zero   = (count_q == '0);
  assign load_big  = ({1'b0, load_val} >= MOD_X);
  assign step_up   = en && (mode == MODE_UP);
  assign step_down = en && (mode == MODE_DOWN);

  // Terminal count: the next enabled step in the current direction wraps.
  assign tc = (step_up && at_max) || (step_down && at_zero);

  // Next-state selection: LOAD beats the enable-gated UP/DOWN, else hold.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    count_d = count_q;
    wrap_d  = 1'b0;
    if (mode == MODE_LOAD) begin
      count_d = load_big ? MAX_C : load_val;
    end else if (step_up) begin
      if (at_max) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (step_down) begin
      if (at_zero) begin
        count_d = MAX_C;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // A wrap on the same edge as a clear keeps the flag set.
  assign ovf_d = wrap_d || (ovf_q && !clr_ovf);

  dff_vec #(
    .WIDTH     (WIDTH),
    .RESET_VAL (WIDTH'(RESET_VAL))
  ) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .d     (count_d),
    .q     (count_q)
  );

  // Wrap pulse and sticky overflow flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign count      = count_q;
  assign wrap       = wrap_q;
  assign ovf_sticky = ovf_q;

endmodule : modn_updown_counter

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: a modulo-10 unit under directed stimulus,
// a modulo-16 twin sharing its inputs, and a two-digit decimal cascade.
module tb_modn_updown_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = MODE_HOLD;
  logic [3:0] load_val = 4'd0;
  logic       clr_ovf = 1'b0;
  logic       c_en = 1'b0;
  logic [1:0] c_mode = MODE_HOLD;
  logic [3:0] c_ld = 4'd0;

  logic [3:0] count, f_count, c0_count, c1_count;
  logic       tc, wrap, ovf_sticky;
  logic       f_tc, f_wrap, f_ovf;
  logic       c0_tc, c0_wrap, c0_ovf, c1_tc, c1_wrap, c1_ovf;

  int n_vec = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(count), .tc(tc), .wrap(wrap), .ovf_sticky(ovf_sticky));

  modn_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) u_full (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(f_count), .tc(f_tc), .wrap(f_wrap), .ovf_sticky(f_ovf));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_c0 (
    .clk(clk), .reset(reset), .en(c_en), .mode(c_mode), .load_val(c_ld),
    .clr_ovf(1'b0), .count(c0_count), .tc(c0_tc), .wrap(c0_wrap), .ovf_sticky(c0_ovf));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_c1 (
    .clk(clk), .reset(reset), .en(c0_tc), .mode(c_mode), .load_val(c_ld),
    .clr_ovf(1'b0), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap), .ovf_sticky(c1_ovf));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int cnt;
    bit wrap;
    bit ovf;
  } mstate_t;

  mstate_t m_dut, m_full, m_c0, m_c1;

  function automatic mstate_t step(mstate_t s, int modulus, logic [1:0] m, logic e,
                                   int ld, logic clr);
    mstate_t r = s;
    r.wrap = 1'b0;
    if (m == MODE_LOAD) begin
      r.cnt = (ld >= modulus) ? modulus - 1 : ld;
    end else if (e && m == MODE_UP) begin
      r.wrap = (s.cnt + 1 == modulus);
      r.cnt  = (s.cnt + 1) % modulus;
    end else if (e && m == MODE_DOWN) begin
      r.wrap = (s.cnt == 0);
      r.cnt  = (s.cnt + modulus - 1) % modulus;
    end
    r.ovf = r.wrap || (s.ovf && !clr);
    return r;
  endfunction

  function automatic bit exp_tc(mstate_t s, int modulus, logic [1:0] m, logic e);
    return e && ((m == MODE_UP && s.cnt == modulus - 1) || (m == MODE_DOWN && s.cnt == 0));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dut  = '{cnt: 3, wrap: 1'b0, ovf: 1'b0};
      m_full = '{cnt: 3, wrap: 1'b0, ovf: 1'b0};
      m_c0   = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
      m_c1   = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
    end else begin : model_step
      bit t0;
      t0     = exp_tc(m_c0, 10, c_mode, c_en);
      m_dut  = step(m_dut, 10, mode, en, int'(load_val), clr_ovf);
      m_full = step(m_full, 16, mode, en, int'(load_val), clr_ovf);
      m_c1   = step(m_c1, 10, c_mode, t0, int'(c_ld), 1'b0);
      m_c0   = step(m_c0, 10, c_mode, c_en, int'(c_ld), 1'b0);
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (cmp_on && !reset) begin
      check("dut.count", 32'(count), 32'(m_dut.cnt));
      check("dut.wrap",  32'(wrap), 32'(m_dut.wrap));
      check("dut.ovf",   32'(ovf_sticky), 32'(m_dut.ovf));
      check("dut.tc",    32'(tc), 32'(exp_tc(m_dut, 10, mode, en)));
      check("full.count", 32'(f_count), 32'(m_full.cnt));
      check("full.wrap",  32'(f_wrap), 32'(m_full.wrap));
      check("full.ovf",   32'(f_ovf), 32'(m_full.ovf));
      check("full.tc",    32'(f_tc), 32'(exp_tc(m_full, 16, mode, en)));
      check("c0.count", 32'(c0_count), 32'(m_c0.cnt));
      check("c0.wrap",  32'(c0_wrap), 32'(m_c0.wrap));
      check("c1.count", 32'(c1_count), 32'(m_c1.cnt));
      check("c1.wrap",  32'(c1_wrap), 32'(m_c1.wrap));
      check("c1.ovf",   32'(c1_ovf), 32'(m_c1.ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic e, input logic [3:0] ld, input logic clr);
    mode = m; en = e; load_val = ld; clr_ovf = clr;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin : stim
    int pulses;
    repeat (2) tick();
    reset = 1'b0;
    cmp_on = 1'b1;
    check("reset.count", 32'(count), 32'd3);

    // Reach a wrap, then reset between edges.
    drive(MODE_LOAD, 1'b0, 4'd9, 1'b0); tick();
    drive(MODE_UP, 1'b1, 4'd0, 1'b0);   tick();
    check("pre_reset.count", 32'(count), 32'd0);
    check("pre_reset.ovf", 32'(ovf_sticky), 32'd1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("async_reset.count", 32'(count), 32'd3);
    check("async_reset.wrap", 32'(wrap), 32'd0);
    check("async_reset.ovf", 32'(ovf_sticky), 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("post_reset.count", 32'(count), 32'd4);

    // Up-wrap over ten edges from zero.
    drive(MODE_LOAD, 1'b0, 4'd0, 1'b1); tick();
    drive(MODE_UP, 1'b1, 4'd0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("up.count", 32'(count), 32'(i % 10));
      check("up.wrap", 32'(wrap), 32'(i == 10));
      check("up.tc", 32'(tc), 32'(i == 9));
      check("up.ovf", 32'(ovf_sticky), 32'(i == 10));
    end

    // Saturating load, then down-wrap from zero.
    drive(MODE_LOAD, 1'b0, 4'd12, 1'b1); tick();
    check("load_sat.count", 32'(count), 32'd9);
    check("load_sat.ovf", 32'(ovf_sticky), 32'd0);
    drive(MODE_LOAD, 1'b0, 4'd0, 1'b0); tick();
    check("load0.count", 32'(count), 32'd0);
    check("load0.wrap", 32'(wrap), 32'd0);
    drive(MODE_DOWN, 1'b1, 4'd0, 1'b0); #1;
    check("down.tc_at0", 32'(tc), 32'd1);
    tick();
    check("down.count", 32'(count), 32'd9);
    check("down.wrap", 32'(wrap), 32'd1);
    tick();
    check("down2.count", 32'(count), 32'd8);
    check("down2.wrap", 32'(wrap), 32'd0);

    // Enable gating at the terminal value, then LOAD ignoring en.
    drive(MODE_LOAD, 1'b0, 4'd9, 1'b0); tick();
    drive(MODE_UP, 1'b0, 4'd0, 1'b0);
    repeat (5) begin
      tick();
      check("gated.count", 32'(count), 32'd9);
      check("gated.tc", 32'(tc), 32'd0);
    end
    drive(MODE_LOAD, 1'b0, 4'd5, 1'b0); tick();
    check("load_no_en.count", 32'(count), 32'd5);
    drive(MODE_HOLD, 1'b1, 4'd0, 1'b0); tick();
    check("hold.count", 32'(count), 32'd5);

    // Overflow set/clear collision.
    drive(MODE_LOAD, 1'b0, 4'd9, 1'b1); tick();
    check("collide_pre.ovf", 32'(ovf_sticky), 32'd0);
    drive(MODE_UP, 1'b1, 4'd0, 1'b1); tick();
    check("collide.count", 32'(count), 32'd0);
    check("collide.ovf", 32'(ovf_sticky), 32'd1);
    drive(MODE_HOLD, 1'b1, 4'd0, 1'b1); tick();
    check("clear.ovf", 32'(ovf_sticky), 32'd0);
    check("clear.wrap", 32'(wrap), 32'd0);
    drive(MODE_HOLD, 1'b0, 4'd0, 1'b0);

    // Two-digit decimal cascade.
    c_mode = MODE_LOAD; c_ld = 4'd0; c_en = 1'b0; tick();
    check("casc_init.c0", 32'(c0_count), 32'd0);
    check("casc_init.c1", 32'(c1_count), 32'd0);
    c_mode = MODE_UP; c_en = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      check("casc.c0", 32'(c0_count), 32'(i % 10));
      check("casc.c1", 32'(c1_count), 32'((i % 100) / 10));
      if (c1_wrap) pulses++;
    end
    check("casc.c1_wrap_pulses", 32'(pulses), 32'd1);
    check("casc.c1_ovf", 32'(c1_ovf), 32'd1);

    c_en = 1'b0;
    tick();
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_modn_updown_counter
